// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared operation encoding and request priority decode for the PC sequencer.
//   op_t      - operation selected for one cycle
//   decode_op - maps request bits to op_t with fixed priority ret > call > load > branch > en
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_BRANCH,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } op_t;

    function automatic op_t decode_op(input logic ret, input logic call, input logic load,
                                      input logic branch, input logic en);
        return ret ? OP_RET : call ? OP_CALL : load ? OP_LOAD : branch ? OP_BRANCH : en ? OP_INC : OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: strict-LIFO return-address stack owning the stack pointer and storage.
//   CLK, RESET_N        - clock, asynchronous active-low reset (clears sp only)
//   push, pop           - requests; never both in one cycle
//   push_data           - address written on an accepted push
//   top                 - entry at sp-1 (zero when empty)
//   empty, full         - sp == 0, sp == STACK_DEPTH
//   ovf_pulse, unf_pulse - push while full / pop while empty (request is ignored)
module pc_return_stack #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf_pulse,
    output logic             unf_pulse
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;

    logic [SPW-1:0]   sp;
    logic [WIDTH-1:0] mem [STACK_DEPTH];

    assign empty     = sp == '0;
    assign full      = sp == SPW'(STACK_DEPTH);
    assign ovf_pulse = push && full;
    assign unf_pulse = pop && empty;
    assign top       = empty ? '0 : mem[AW'(sp - SPW'(1))];

    // Storage shares the reset process so a push coinciding with reset is dropped.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[AW'(sp)] <= push_data;
            sp           <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: WIDTH-bit program counter with increment, jump, relative branch and call/return.
//   CLK, RESET_N                - clock, asynchronous active-low reset
//   en, load, branch, call, ret - operation requests (priority ret > call > load > branch > en)
//   addr, off                   - jump/call target, two's-complement branch offset
//   OE                          - capture the pre-update pc into bus_out
//   clr_err                     - clear sticky error flags (a new error the same cycle wins)
//   pc, bus_out                 - registered PC and its registered bus copy
//   on                          - mirrors en
//   stack_empty, stack_full     - return stack status
//   overflow_err, underflow_err - sticky call-when-full / ret-when-empty flags
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             en,
    input  logic             load,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] off,
    input  logic             OE,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] bus_out,
    output logic             on,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             overflow_err,
    output logic             underflow_err
);

    op_t              op;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] pc_next;
    logic             ovf_pulse;
    logic             unf_pulse;

    assign op = decode_op(ret, call, load, branch, en);
    assign on = en;

    pc_return_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .push_data (pc + WIDTH'(1)),
        .top       (top),
        .empty     (stack_empty),
        .full      (stack_full),
        .ovf_pulse (ovf_pulse),
        .unf_pulse (unf_pulse)
    );

    // A rejected call or ret leaves the pc untouched rather than jumping.
    always_comb begin
        pc_next = op == OP_RET    ? (stack_empty ? pc : top)
                : op == OP_CALL   ? (stack_full ? pc : addr)
                : op == OP_LOAD   ? addr
                : op == OP_BRANCH ? pc + off
                : op == OP_INC    ? pc + WIDTH'(1)
                : pc;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc            <= RESET_VECTOR;
            bus_out       <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pc            <= pc_next;
            bus_out       <= OE ? pc : bus_out;
            overflow_err  <= ovf_pulse || (overflow_err && !clr_err);
            underflow_err <= unf_pulse || (underflow_err && !clr_err);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus checked against an arithmetic reference model every cycle,
// plus literal expectations taken from hand-worked sequences.
module tb_pc_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       en, load, branch, call, ret, OE, clr_err;
    logic [7:0] addr, off;
    logic [7:0] pc, bus_out;
    logic       on, stack_empty, stack_full, overflow_err, underflow_err;

    int compared = 0;
    int mismatched = 0;

    int m_pc = 16, m_bus = 0, m_sp = 0;
    bit m_ovf = 0, m_unf = 0;
    int m_stk [4];

    pc_sequencer #(.WIDTH(8), .STACK_DEPTH(4), .RESET_VECTOR(8'h10)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .en            (en),
        .load          (load),
        .branch        (branch),
        .call          (call),
        .ret           (ret),
        .addr          (addr),
        .off           (off),
        .OE            (OE),
        .clr_err       (clr_err),
        .pc            (pc),
        .bus_out       (bus_out),
        .on            (on),
        .stack_empty   (stack_empty),
        .stack_full    (stack_full),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural rules applied with plain integer arithmetic mod 256.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_pc <= 16; m_bus <= 0; m_sp <= 0; m_ovf <= 0; m_unf <= 0;
        end else begin
            if (OE) m_bus <= m_pc;
            m_ovf <= (m_ovf && !clr_err) || (call && !ret && m_sp == 4);
            m_unf <= (m_unf && !clr_err) || (ret && m_sp == 0);
            if (ret) begin
                if (m_sp > 0) begin m_pc <= m_stk[m_sp-1]; m_sp <= m_sp - 1; end
            end else if (call) begin
                if (m_sp < 4) begin m_stk[m_sp] <= (m_pc + 1) % 256; m_sp <= m_sp + 1; m_pc <= addr; end
            end else if (load) m_pc <= addr;
            else if (branch) m_pc <= (m_pc + off) % 256;
            else if (en) m_pc <= (m_pc + 1) % 256;
        end
    end

    always @(negedge CLK) begin
        if (RESET_N) begin
            chk("m_pc", pc, m_pc);
            chk("m_bus", bus_out, m_bus);
            chk("m_empty", stack_empty, m_sp == 0);
            chk("m_full", stack_full, m_sp == 4);
            chk("m_ovf", overflow_err, m_ovf);
            chk("m_unf", underflow_err, m_unf);
        end
    end

    task automatic idle();
        en = 0; load = 0; branch = 0; call = 0; ret = 0; OE = 0; clr_err = 0; addr = 0; off = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        idle();
    endtask

    initial begin
        idle();
        repeat (2) @(negedge CLK);
        chk("rst_pc", pc, 8'h10);
        chk("rst_bus", bus_out, 8'h00);
        chk("rst_empty", stack_empty, 1'b1);
        chk("rst_full", stack_full, 1'b0);
        chk("rst_flags", {overflow_err, underflow_err}, 2'b00);
        RESET_N = 1;

        en = 1; #1 chk("on_hi", on, 1'b1);
        step(); chk("inc1", pc, 8'h11);
        en = 1; step();
        en = 1; step(); chk("inc3", pc, 8'h13);
        chk("bus_before_oe", bus_out, 8'h00);
        #1 chk("on_lo", on, 1'b0);
        OE = 1; en = 1; step();
        chk("bus_oe", bus_out, 8'h13);
        chk("pc_after_oe", pc, 8'h14);

        load = 1; addr = 8'hFE; step();
        en = 1; step(); chk("inc_ff", pc, 8'hFF);
        en = 1; step(); chk("wrap_00", pc, 8'h00);
        en = 1; step(); chk("inc_01", pc, 8'h01);
        branch = 1; off = 8'hFC; step(); chk("branch_neg", pc, 8'hFD);

        load = 1; addr = 8'h20; step();
        call = 1; addr = 8'h80; step(); chk("call1", pc, 8'h80);
        chk("call1_nonempty", stack_empty, 1'b0);
        en = 1; step();
        call = 1; addr = 8'hA0; step(); chk("call2", pc, 8'hA0);
        ret = 1; step(); chk("ret2", pc, 8'h82);
        ret = 1; step(); chk("ret1", pc, 8'h21);
        chk("ret1_empty", stack_empty, 1'b1);

        for (int i = 1; i <= 4; i++) begin call = 1; addr = 8'(i); step(); end
        chk("fill_full", stack_full, 1'b1);
        call = 1; addr = 8'h55; step(); chk("ovf_pc", pc, 8'h04);
        chk("ovf_set", overflow_err, 1'b1);
        step(); chk("ovf_sticky", overflow_err, 1'b1);
        clr_err = 1; step(); chk("ovf_clr", overflow_err, 1'b0);
        for (int i = 0; i < 4; i++) begin ret = 1; step(); end
        chk("unwind", pc, 8'h22);
        ret = 1; step(); chk("unf_pc", pc, 8'h22);
        chk("unf_set", underflow_err, 1'b1);

        load = 1; addr = 8'h43; step();
        call = 1; addr = 8'h60; step();
        ret = 1; call = 1; load = 1; en = 1; addr = 8'h77; step();
        chk("prio_ret", pc, 8'h44);
        chk("prio_empty", stack_empty, 1'b1);
        clr_err = 1; ret = 1; step(); chk("set_wins", underflow_err, 1'b1);
        clr_err = 1; step(); chk("unf_clr", underflow_err, 1'b0);
        load = 1; branch = 1; en = 1; addr = 8'h30; off = 8'h05; step();
        chk("prio_load", pc, 8'h30);

        load = 1; addr = 8'hFF; step();
        call = 1; addr = 8'h10; step();
        ret = 1; step(); chk("call_ff_ret", pc, 8'h00);

        load = 1; addr = 8'h50; OE = 1; step();
        OE = 1; step(); chk("bus_50", bus_out, 8'h50);
        ret = 1; step();
        call = 1; addr = 8'h90;
        #2 RESET_N = 0;
        #1 chk("arst_pc", pc, 8'h10);
        chk("arst_bus", bus_out, 8'h00);
        chk("arst_flags", {overflow_err, underflow_err}, 2'b00);
        @(posedge CLK);
        @(negedge CLK);
        chk("arst_no_push", stack_empty, 1'b1);
        chk("arst_hold_pc", pc, 8'h10);
        idle();
        RESET_N = 1;
        ret = 1; step(); chk("post_rst_unf", underflow_err, 1'b1);
        chk("post_rst_pc", pc, 8'h10);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
